// File: rtl/mor1kx_store_drain.sv
// Store buffer drain: pops one entry at a time and issues it as a single
// Wishbone classic write, resolving store-conditional entries against the
// LSU reservation. The first bus error or timeout is latched with its address/PC.
module mor1kx_store_drain #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int TIMEOUT_WIDTH        = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_dat_i,
  input  logic [OPTION_OPERAND_WIDTH/8-1:0] sb_bsel_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_pc_i,
  input  logic                              sb_atomic_i,
  input  logic                              sb_empty_i,
  output logic                              sb_read_o,
  input  logic                              atomic_reserve_i,
  output logic                              atomic_result_o,
  output logic                              atomic_success_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   wbm_adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   wbm_dat_o,
  output logic [OPTION_OPERAND_WIDTH/8-1:0] wbm_sel_o,
  output logic                              wbm_we_o,
  output logic                              wbm_cyc_o,
  output logic                              wbm_stb_o,
  input  logic                              wbm_ack_i,
  input  logic                              wbm_err_i,
  output logic                              err_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   err_adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   err_pc_o,
  input  logic                              err_clear_i,
  output logic                              idle_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POP   = 2'd1,
    WRITE = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t                            state;
  logic [TIMEOUT_WIDTH-1:0]          tmo_cnt;
  logic [TIMEOUT_WIDTH-1:0]          tmo_nxt;
  logic                              tmo_hit;
  logic [OPTION_OPERAND_WIDTH-1:0]   pc_q;
  logic                              atomic_q;

  // Pop strobe depends only on state and flags, so it can never fire while
  // the buffer is empty, during reset, or while an error is pending.
  assign sb_read_o = rst_n & (state == IDLE) & ~sb_empty_i & ~err_o;
  assign idle_o    = (state == IDLE) & sb_empty_i;

  // Saturating wait counter; the cycle in which it would reach all-ones is
  // the last one that can still be acked (2^W-1 cycles of cyc in total).
  always_comb begin
    tmo_nxt = (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + 1'b1;
    tmo_hit = (tmo_nxt == '1);
  end

  // Drain FSM with registered bus, result and error outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      tmo_cnt          <= '0;
      pc_q             <= '0;
      atomic_q         <= 1'b0;
      atomic_result_o  <= 1'b0;
      atomic_success_o <= 1'b0;
      wbm_adr_o        <= '0;
      wbm_dat_o        <= '0;
      wbm_sel_o        <= '0;
      wbm_we_o         <= 1'b0;
      wbm_cyc_o        <= 1'b0;
      wbm_stb_o        <= 1'b0;
      err_o            <= 1'b0;
      err_adr_o        <= '0;
      err_pc_o         <= '0;
    end else begin
      atomic_result_o  <= 1'b0;
      atomic_success_o <= 1'b0;
      case (state)
        IDLE: begin
          if (!sb_empty_i && !err_o) state <= POP;
        end
        POP: begin
          // Registered store buffer RAM: entry is valid now.
          wbm_adr_o <= sb_adr_i;
          wbm_dat_o <= sb_dat_i;
          wbm_sel_o <= sb_bsel_i;
          pc_q      <= sb_pc_i;
          atomic_q  <= sb_atomic_i;
          tmo_cnt   <= '0;
          if (sb_atomic_i && !atomic_reserve_i) begin
            // Lost reservation: the store-conditional fails without a bus cycle.
            atomic_result_o <= 1'b1;
            state           <= IDLE;
          end else begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= 1'b1;
            state     <= WRITE;
          end
        end
        WRITE: begin
          tmo_cnt <= tmo_nxt;
          if (wbm_err_i || (!wbm_ack_i && tmo_hit)) begin
            // Error has priority over a simultaneous ack.
            wbm_cyc_o       <= 1'b0;
            wbm_stb_o       <= 1'b0;
            wbm_we_o        <= 1'b0;
            err_o           <= 1'b1;
            err_adr_o       <= wbm_adr_o;
            err_pc_o        <= pc_q;
            atomic_result_o <= atomic_q;
            state           <= ERR;
          end else if (wbm_ack_i) begin
            wbm_cyc_o        <= 1'b0;
            wbm_stb_o        <= 1'b0;
            wbm_we_o         <= 1'b0;
            atomic_result_o  <= atomic_q;
            atomic_success_o <= atomic_q;
            state            <= IDLE;
          end
        end
        ERR: begin
          // Faulting entry is dropped; draining resumes with the next one.
          if (err_clear_i) begin
            err_o <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mor1kx_store_drain.sv
// Directed bench for mor1kx_store_drain: a registered store buffer model and
// a Wishbone responder with programmable ack/err delay, driven cycle by cycle.
module tb_mor1kx_store_drain;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] sb_adr_i, sb_dat_i, sb_pc_i;
  logic [3:0]  sb_bsel_i;
  logic        sb_atomic_i, sb_empty_i, sb_read_o;
  logic        atomic_reserve_i, atomic_result_o, atomic_success_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i, wbm_err_i;
  logic        err_o, err_clear_i, idle_o;
  logic [31:0] err_adr_o, err_pc_o;

  mor1kx_store_drain #(.OPTION_OPERAND_WIDTH(32), .TIMEOUT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .sb_adr_i(sb_adr_i), .sb_dat_i(sb_dat_i), .sb_bsel_i(sb_bsel_i),
    .sb_pc_i(sb_pc_i), .sb_atomic_i(sb_atomic_i), .sb_empty_i(sb_empty_i),
    .sb_read_o(sb_read_o), .atomic_reserve_i(atomic_reserve_i),
    .atomic_result_o(atomic_result_o), .atomic_success_o(atomic_success_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
    .err_o(err_o), .err_adr_o(err_adr_o), .err_pc_o(err_pc_o),
    .err_clear_i(err_clear_i), .idle_o(idle_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Store buffer model contents
  logic [31:0] mem_adr [32];
  logic [31:0] mem_dat [32];
  logic [3:0]  mem_sel [32];
  logic [31:0] mem_pc  [32];
  logic        mem_atm [32];
  int          wr = 0, rd = 0;

  // Observation state
  int          cyc_n = 0, pops = 0, res_cnt = 0, cyc_seen = 0;
  int          pop_cyc [32];
  logic        last_succ = 1'b0;
  logic [31:0] log_adr [32];
  logic [31:0] log_dat [32];
  int          log_n = 0;
  int          wait_cnt = 0, last_len = 0, unstable = 0;
  logic [31:0] first_adr, first_dat;
  logic [3:0]  first_sel;

  // Responder mode
  int ack_dly  = 0;
  bit resp_ack = 1'b1;
  bit resp_err = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input logic [31:0] pc, input logic atm);
    mem_adr[wr] = adr; mem_dat[wr] = dat; mem_sel[wr] = sel;
    mem_pc[wr]  = pc;  mem_atm[wr] = atm;
    wr++;
    sb_empty_i = 1'b0;
  endtask

  // One clock: sample at negedge, respond, then update the RAM model after the edge.
  task automatic step();
    logic pop;
    @(negedge clk);
    pop = sb_read_o;
    if (pop) begin
      pop_cyc[pops] = cyc_n;
      pops++;
    end
    if (wbm_cyc_o) begin
      cyc_seen++;
      if (wait_cnt == 0) begin
        first_adr = wbm_adr_o; first_dat = wbm_dat_o; first_sel = wbm_sel_o;
      end else if (wbm_adr_o !== first_adr || wbm_dat_o !== first_dat ||
                   wbm_sel_o !== first_sel || !wbm_stb_o || !wbm_we_o) begin
        unstable++;
      end
      if (wait_cnt == ack_dly) begin
        wbm_ack_i = resp_ack;
        wbm_err_i = resp_err;
        if (resp_ack && !resp_err) begin
          log_adr[log_n] = wbm_adr_o;
          log_dat[log_n] = wbm_dat_o;
          log_n++;
        end
      end
      wait_cnt++;
    end else if (wait_cnt != 0) begin
      last_len = wait_cnt;
      wait_cnt = 0;
    end
    @(posedge clk);
    #1;
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    cyc_n++;
    if (atomic_result_o) begin
      res_cnt++;
      last_succ = atomic_success_o;
    end
    if (pop) begin
      sb_adr_i = mem_adr[rd]; sb_dat_i = mem_dat[rd]; sb_bsel_i = mem_sel[rd];
      sb_pc_i  = mem_pc[rd];  sb_atomic_i = mem_atm[rd];
      rd++;
    end
    sb_empty_i = (rd == wr);
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (idle_o && !wbm_cyc_o) break;
    end
    chk(tag, idle_o, 1);
    step();
    step();
  endtask

  task automatic wait_err(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (err_o) break;
    end
    chk(tag, err_o, 1);
  endtask

  task automatic clear_err();
    err_clear_i = 1'b1;
    step();
    err_clear_i = 1'b0;
  endtask

  int p0, l0, r0, c0;

  initial begin
    rst_n = 1'b0;
    sb_adr_i = '0; sb_dat_i = '0; sb_bsel_i = '0; sb_pc_i = '0; sb_atomic_i = 1'b0;
    sb_empty_i = 1'b1; atomic_reserve_i = 1'b1;
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0; err_clear_i = 1'b0;

    // Reset values
    step(); step();
    chk("rst_read", sb_read_o, 0);
    chk("rst_cyc", {wbm_cyc_o, wbm_stb_o, wbm_we_o}, 0);
    chk("rst_err", {err_o, atomic_result_o, atomic_success_o}, 0);
    chk("rst_adr", {wbm_adr_o, err_adr_o}, 0);
    chk("rst_idle", idle_o, 1);
    rst_n = 1'b1;
    step();

    // Single entry, ack on third bus cycle
    p0 = pops; l0 = log_n; ack_dly = 2;
    push(32'h100, 32'hDEADBEEF, 4'hF, 32'h10, 1'b0);
    run_until_idle("t1_idle", 30);
    chk("t1_pops", pops - p0, 1);
    chk("t1_nwr", log_n - l0, 1);
    chk("t1_adr", log_adr[l0], 32'h100);
    chk("t1_dat", log_dat[l0], 32'hDEADBEEF);
    chk("t1_len", last_len, 3);
    chk("t1_stable", unstable, 0);

    // Four entries, immediate ack: order and 3-cycle spacing
    p0 = pops; l0 = log_n; ack_dly = 0;
    for (int i = 0; i < 4; i++)
      push(32'h200 + 32'(i * 4), 32'hA0 + 32'(i), 4'h3, 32'h20, 1'b0);
    run_until_idle("t2_idle", 40);
    chk("t2_pops", pops - p0, 4);
    chk("t2_nwr", log_n - l0, 4);
    for (int i = 0; i < 4; i++)
      chk("t2_order", log_adr[l0 + i], 32'h200 + 32'(i * 4));
    for (int i = 1; i < 4; i++)
      chk("t2_space", pop_cyc[p0 + i] - pop_cyc[p0 + i - 1], 3);

    // Atomic with lost reservation: no bus cycle, failure pulse
    c0 = cyc_seen; r0 = res_cnt; atomic_reserve_i = 1'b0;
    push(32'h300, 32'h1, 4'hF, 32'h30, 1'b1);
    run_until_idle("t3a_idle", 20);
    chk("t3a_nocyc", cyc_seen - c0, 0);
    chk("t3a_res", res_cnt - r0, 1);
    chk("t3a_succ", last_succ, 0);

    // Atomic with reservation held: write issued, success pulse
    l0 = log_n; r0 = res_cnt; atomic_reserve_i = 1'b1;
    push(32'h304, 32'h2, 4'hF, 32'h34, 1'b1);
    run_until_idle("t3b_idle", 20);
    chk("t3b_nwr", log_n - l0, 1);
    chk("t3b_res", res_cnt - r0, 1);
    chk("t3b_succ", last_succ, 1);

    // Bus error latches address/PC, blocks draining until cleared
    p0 = pops; l0 = log_n; resp_ack = 1'b0; resp_err = 1'b1; ack_dly = 1;
    push(32'h2000, 32'h5, 4'hF, 32'h44, 1'b0);
    push(32'h2004, 32'h6, 4'hF, 32'h48, 1'b0);
    push(32'h2008, 32'h7, 4'hF, 32'h4C, 1'b0);
    wait_err("t4_err", 20);
    for (int i = 0; i < 10; i++) step();
    chk("t4_err_hold", err_o, 1);
    chk("t4_eadr", err_adr_o, 32'h2000);
    chk("t4_epc", err_pc_o, 32'h44);
    chk("t4_blocked", pops - p0, 1);
    chk("t4_idle", idle_o, 0);
    resp_ack = 1'b1; resp_err = 1'b0; ack_dly = 0;
    clear_err();
    run_until_idle("t4_resume", 30);
    chk("t4_err_clr", err_o, 0);
    chk("t4_pops", pops - p0, 3);
    chk("t4_nwr", log_n - l0, 2);
    chk("t4_next", log_adr[l0], 32'h2004);

    // No response: timeout after 255 cycles of cyc
    ack_dly = -1;
    push(32'h3000, 32'h8, 4'hF, 32'h50, 1'b0);
    wait_err("t5_tmo_err", 300);
    step();
    chk("t5_tmo_len", last_len, 255);
    chk("t5_tmo_eadr", err_adr_o, 32'h3000);
    chk("t5_tmo_epc", err_pc_o, 32'h50);
    clear_err();

    // Ack in the final (timeout) cycle still counts as ack
    l0 = log_n; ack_dly = 254;
    push(32'h3100, 32'h9, 4'hF, 32'h54, 1'b0);
    run_until_idle("t5_edge_idle", 300);
    chk("t5_edge_err", err_o, 0);
    chk("t5_edge_len", last_len, 255);
    chk("t5_edge_nwr", log_n - l0, 1);

    // Ack and err together: error wins
    l0 = log_n; ack_dly = 0; resp_ack = 1'b1; resp_err = 1'b1;
    push(32'h3200, 32'hA, 4'hF, 32'h58, 1'b0);
    wait_err("t5_both_err", 20);
    chk("t5_both_eadr", err_adr_o, 32'h3200);
    chk("t5_both_nwr", log_n - l0, 0);
    resp_err = 1'b0;
    clear_err();

    // Asynchronous reset during WRITE
    ack_dly = -1;
    push(32'h4000, 32'hB, 4'hF, 32'h60, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      if (wbm_cyc_o) break;
    end
    chk("t6_incyc", wbm_cyc_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_cyc", {wbm_cyc_o, wbm_stb_o, wbm_we_o}, 0);
    chk("t6_adr", {wbm_adr_o, wbm_dat_o}, 0);
    chk("t6_misc", {sb_read_o, err_o, atomic_result_o}, 0);
    step(); step();
    rst_n = 1'b1;
    step(); step();
    chk("t6_idle", idle_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
